// File: rtl/ethernet_header_pkg.sv
// Shared Ethernet header definitions and the TX arbiter state encoding.
package ethernet_header_pkg;

  localparam int unsigned ETH_HDR_W = 112;

  typedef struct packed {
    logic [47:0] src_mac;
    logic [47:0] dest_mac;
    logic [15:0] ethertype;
  } eth_hdr_t;

  typedef enum logic {StIdle, StActive} arb_state_e;

endpackage

// File: rtl/eth_tx_arbiter.sv
// Two-requester, packet-granular round-robin arbiter feeding one header+payload
// pair into packet_tx. Routing is combinational; grant and completion are registered.
module eth_tx_arbiter
  import ethernet_header_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned HDR_W  = ETH_HDR_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [HDR_W-1:0]  s0_header,
  input  logic              s0_header_valid,
  output logic              s0_header_rd,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  input  logic [HDR_W-1:0]  s1_header,
  input  logic              s1_header_valid,
  output logic              s1_header_rd,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [HDR_W-1:0]  header,
  output logic              header_valid,
  input  logic              header_rd,
  output logic              busy,
  output logic              grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             hdr_done_q, hdr_done_d;
  logic             data_done_q, data_done_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             hdr_fire;
  logic             data_fire;
  logic             rdy;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    hdr_done_d     = hdr_done_q;
    data_done_d    = data_done_q;
    cnt0_d         = cnt0_q;
    cnt1_d         = cnt1_q;
    hdr_fire       = 1'b0;
    data_fire      = 1'b0;
    rdy            = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    s0_header_rd   = 1'b0;
    s1_header_rd   = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    header         = '0;
    header_valid   = 1'b0;

    case (state_q)
      StIdle: begin
        if (s0_header_valid || s1_header_valid) begin
          state_d     = StActive;
          // On a tie the requester not served last wins; otherwise the lone requester.
          grant_d     = (s0_header_valid && s1_header_valid) ? ~last_grant_q : s1_header_valid;
          hdr_done_d  = 1'b0;
          data_done_d = 1'b0;
        end
      end
      StActive: begin
        header        = grant_q ? s1_header : s0_header;
        header_valid  = ~hdr_done_q & (grant_q ? s1_header_valid : s0_header_valid);
        m_axis_tdata  = grant_q ? s1_axis_tdata : s0_axis_tdata;
        m_axis_tlast  = grant_q ? s1_axis_tlast : s0_axis_tlast;
        // Once the payload tlast has gone through, hold the source off so the next
        // queued packet cannot leak into this grant.
        m_axis_tvalid = ~data_done_q & (grant_q ? s1_axis_tvalid : s0_axis_tvalid);
        rdy           = ~data_done_q & m_axis_tready;
        hdr_fire      = header_rd & header_valid;
        data_fire     = m_axis_tvalid & m_axis_tready & m_axis_tlast;
        if (grant_q) begin
          s1_axis_tready = rdy;
          s1_header_rd   = hdr_fire;
        end else begin
          s0_axis_tready = rdy;
          s0_header_rd   = hdr_fire;
        end
        hdr_done_d  = hdr_done_q | hdr_fire;
        data_done_d = data_done_q | data_fire;
        if (hdr_done_d && data_done_d) begin
          state_d      = StIdle;
          last_grant_d = grant_q;
          hdr_done_d   = 1'b0;
          data_done_d  = 1'b0;
          if (grant_q) cnt1_d = cnt1_q + CntOne;
          else         cnt0_d = cnt0_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      hdr_done_q   <= 1'b0;
      data_done_q  <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hdr_done_q   <= hdr_done_d;
      data_done_q  <= data_done_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign busy     = (state_q == StActive);
  assign grant    = grant_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: source/sink models plus byte and grant scoreboards.
module tb_eth_tx_arbiter;
  import ethernet_header_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned HDR_W  = 112;
  localparam int unsigned CNT_W  = 16;

  localparam eth_hdr_t Hdr0 = '{src_mac: 48'h00183E04B3F2, dest_mac: 48'h54E1AD330D32,
                                ethertype: 16'h0800};
  localparam eth_hdr_t Hdr1 = '{src_mac: 48'h020000000001, dest_mac: 48'h020000000002,
                                ethertype: 16'h86DD};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] s0_axis_tdata = '0, s1_axis_tdata = '0;
  logic              s0_axis_tvalid = 1'b0, s1_axis_tvalid = 1'b0;
  logic              s0_axis_tlast = 1'b0, s1_axis_tlast = 1'b0;
  logic              s0_axis_tready, s1_axis_tready;
  logic [HDR_W-1:0]  s0_header = Hdr0, s1_header = Hdr1;
  logic              s0_header_valid = 1'b0, s1_header_valid = 1'b0;
  logic              s0_header_rd, s1_header_rd;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tlast;
  logic              m_axis_tready = 1'b1;
  logic [HDR_W-1:0]  header;
  logic              header_valid;
  logic              header_rd = 1'b0;
  logic              busy, grant;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

  eth_tx_arbiter #(.DATA_W(DATA_W), .HDR_W(HDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s0_header(s0_header), .s0_header_valid(s0_header_valid), .s0_header_rd(s0_header_rd),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .s1_header(s1_header), .s1_header_valid(s1_header_valid), .s1_header_rd(s1_header_rd),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .header(header), .header_valid(header_valid), .header_rd(header_rd),
    .busy(busy), .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source queues hold {tlast, tdata}; exp queues are the sink-side scoreboard.
  logic [8:0] src0_q[$], src1_q[$], exp0_q[$], exp1_q[$];
  logic       gq[$];
  int         hdr_pend0 = 0, hdr_pend1 = 0;
  int         viol = 0, xfer_cnt = 0;
  bit         tlast_seen = 0, auto_hdr = 1, man_hdr_rd = 0, tog = 0;
  logic       busy_prev = 1'b0;
  logic       f0, f1, h0, h1, hv, hr;
  logic [8:0] e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic enq(input int src, input int pkt, input int len);
    logic [8:0] b;
    int v;
    for (int k = 0; k < len; k++) begin
      v = (src != 0 ? 128 : 0) + pkt * 16 + 17 + k;
      b = {(k == len - 1), v[7:0]};
      if (src != 0) begin src1_q.push_back(b); exp1_q.push_back(b); end
      else begin src0_q.push_back(b); exp0_q.push_back(b); end
    end
    if (src != 0) hdr_pend1++;
    else hdr_pend0++;
  endtask

  task automatic flush();
    src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete(); gq.delete();
    hdr_pend0 = 0; hdr_pend1 = 0; tlast_seen = 0; xfer_cnt = 0; viol = 0;
  endtask

  // Called at negedge+2; flushes once the DUT has sat in reset for a full cycle.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk); #2;
    flush();
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(src0_q.size() == 0 && src1_q.size() == 0 && hdr_pend0 == 0 && hdr_pend1 == 0
             && !busy) && n < 2000) begin
      @(negedge clk); #2;
      n++;
    end
    chk({name, "_done_in_time"}, n < 2000, 1);
  endtask

  // Monitor at negedge, then act on the sampled handshakes just after the next posedge.
  always begin
    @(negedge clk);
    f0 = s0_axis_tvalid & s0_axis_tready;
    f1 = s1_axis_tvalid & s1_axis_tready;
    h0 = s0_header_rd;
    h1 = s1_header_rd;
    hv = header_valid;
    hr = header_rd;
    if (busy && !busy_prev) begin
      if (gq.size() == 0) chk("unexpected_grant", 1, 0);
      else chk("grant_order", grant, gq.pop_front());
    end
    busy_prev = busy;
    if (!busy) begin
      if (s0_axis_tready | s1_axis_tready | s0_header_rd | s1_header_rd | m_axis_tvalid
          | header_valid) viol++;
    end else if (grant ? (s0_axis_tready | s0_header_rd) : (s1_axis_tready | s1_header_rd)) begin
      viol++;
    end
    if (hv && hr) chk("header_value", header, grant ? Hdr1 : Hdr0);
    if (m_axis_tvalid && m_axis_tready) begin
      xfer_cnt++;
      if (m_axis_tlast) tlast_seen = 1;
      if (grant ? exp1_q.size() == 0 : exp0_q.size() == 0) chk("extra_byte", 1, 0);
      else begin
        e = grant ? exp1_q.pop_front() : exp0_q.pop_front();
        chk("m_axis_byte", {m_axis_tlast, m_axis_tdata}, e);
      end
    end
    @(posedge clk); #1;
    if (f0 && src0_q.size() > 0) void'(src0_q.pop_front());
    if (f1 && src1_q.size() > 0) void'(src1_q.pop_front());
    if (h0) hdr_pend0--;
    if (h1) hdr_pend1--;
    s0_header_valid = hdr_pend0 > 0;
    s1_header_valid = hdr_pend1 > 0;
    s0_axis_tvalid  = src0_q.size() > 0;
    s1_axis_tvalid  = src1_q.size() > 0;
    {s0_axis_tlast, s0_axis_tdata} = (src0_q.size() > 0) ? src0_q[0] : 9'h0;
    {s1_axis_tlast, s1_axis_tdata} = (src1_q.size() > 0) ? src1_q[0] : 9'h0;
    m_axis_tready = tog ? ~m_axis_tready : 1'b1;
    header_rd     = auto_hdr ? (hv && !hr) : man_hdr_rd;
  end

  typedef struct {
    int         n0;
    int         n1;
    int         len;
    bit         tog;
    int         ng;
    logic [3:0] g;   // g[i] = expected i-th grant
    int         c0;
    int         c1;
  } vec_t;

  vec_t vecs[7];
  bit   ok;
  int   n;

  initial begin
    vecs[0] = '{1, 0, 4, 1'b0, 1, 4'b0000, 1, 0};  // s0 alone, 0x11..0x14
    vecs[1] = '{1, 1, 5, 1'b0, 2, 4'b0010, 1, 1};  // tie from reset: s0 then s1
    vecs[2] = '{2, 2, 3, 1'b0, 4, 4'b1010, 2, 2};  // both busy: alternate 0,1,0,1
    vecs[3] = '{0, 1, 1, 1'b0, 1, 4'b0001, 0, 1};  // s1 alone, single byte
    vecs[4] = '{3, 0, 2, 1'b0, 3, 4'b0000, 3, 0};  // s0 back-to-back
    vecs[5] = '{1, 0, 8, 1'b1, 1, 4'b0000, 1, 0};  // tready toggling, 8 bytes
    vecs[6] = '{1, 2, 2, 1'b0, 3, 4'b0110, 1, 2};  // s1 repeats once s0 drained

    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_pkt_cnt0", pkt_cnt0, 0);
    chk("rst_pkt_cnt1", pkt_cnt1, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_header_valid", header_valid, 0);
    chk("rst_readies", {s0_axis_tready, s1_axis_tready, s0_header_rd, s1_header_rd}, 0);
    @(negedge clk); #2;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      do_reset();
      tog = vecs[i].tog;
      auto_hdr = 1;
      for (int p = 0; p < vecs[i].n0; p++) enq(0, p, vecs[i].len);
      for (int p = 0; p < vecs[i].n1; p++) enq(1, p, vecs[i].len);
      for (int g = 0; g < vecs[i].ng; g++) gq.push_back(vecs[i].g[g]);
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_pkt_cnt0", i), pkt_cnt0, vecs[i].c0);
      chk($sformatf("vec%0d_pkt_cnt1", i), pkt_cnt1, vecs[i].c1);
      chk($sformatf("vec%0d_bytes_left", i), exp0_q.size() + exp1_q.size(), 0);
      chk($sformatf("vec%0d_grants_left", i), gq.size(), 0);
      chk($sformatf("vec%0d_exclusivity", i), viol, 0);
      tog = 0;
    end

    // Header consumed well after the payload: must hold ACTIVE until header_rd.
    do_reset();
    auto_hdr = 0;
    man_hdr_rd = 0;
    enq(0, 0, 3);
    gq.push_back(1'b0);
    n = 0;
    while (!tlast_seen && n < 200) begin @(negedge clk); #2; n++; end
    chk("late_hdr_tlast_seen", n < 200, 1);
    ok = 1;
    repeat (3) begin @(negedge clk); #2; ok &= busy; end
    chk("late_hdr_hold_active", ok, 1);
    man_hdr_rd = 1;
    @(negedge clk); #2;
    chk("late_hdr_busy_at_rd", busy, 1);
    man_hdr_rd = 0;
    @(negedge clk); #2;
    chk("late_hdr_idle_after", busy, 0);
    chk("late_hdr_pkt_cnt0", pkt_cnt0, 1);
    chk("late_hdr_header_popped", hdr_pend0, 0);
    auto_hdr = 1;

    // Reset in the middle of a 6-byte payload.
    do_reset();
    enq(0, 0, 6);
    gq.push_back(1'b0);
    n = 0;
    while (xfer_cnt < 2 && n < 200) begin @(negedge clk); #2; n++; end
    chk("mid_rst_reached_byte2", n < 200, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outputs", {s0_axis_tready, m_axis_tvalid, header_valid, s0_header_rd}, 0);
    chk("mid_rst_pkt_cnt0", pkt_cnt0, 0);
    @(negedge clk); @(negedge clk); #2;
    flush();
    rst = 1'b0;
    enq(0, 1, 3);
    gq.push_back(1'b0);
    wait_done("post_rst");
    chk("post_rst_pkt_cnt0", pkt_cnt0, 1);
    chk("post_rst_bytes_left", exp0_q.size(), 0);
    chk("post_rst_grants_left", gq.size(), 0);
    chk("post_rst_exclusivity", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, stream byte width.
REQ-002 Parameter: HDR_W, 112, header width; layout {src_mac[47:0], dest_mac[47:0], ethertype[15:0]}.
REQ-003 Parameter: CNT_W, 16, width of per-port packet counters.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: sN_axis_tdata / sN_axis_tvalid / sN_axis_tlast  in  DATA_W/1/1  payload stream of requester N (N=0,1).
REQ-007 Port: sN_axis_tready  out  1  ready to requester N.
REQ-008 Port: sN_header / sN_header_valid  in  HDR_W/1  pending header of requester N; valid means one packet is queued.
REQ-009 Port: sN_header_rd  out  1  one-cycle pulse; header of requester N consumed.
REQ-010 Port: m_axis_tdata / m_axis_tvalid / m_axis_tlast  out  DATA_W/1/1  stream to packet_tx.
REQ-011 Port: m_axis_tready  in  1  ready from packet_tx.
REQ-012 Port: header / header_valid  out  HDR_W/1  header to packet_tx.
REQ-013 Port: header_rd  in  1  one-cycle consume pulse from packet_tx.
REQ-014 Port: busy  out  1  a packet is granted and in progress.
REQ-015 Port: grant  out  1  index of granted requester (valid while busy).
REQ-016 Port: pkt_cnt0 / pkt_cnt1  out  CNT_W  completed packets per requester.

Function
REQ-017 FSM states IDLE, ACTIVE; packet-granular arbitration, no interleaving of two packets.
REQ-018 IDLE: if any sN_header_valid, register grant and enter ACTIVE next cycle; no output handshake in the grant cycle (1-cycle arbitration latency).
REQ-019 Both valid in IDLE: grant the requester not served last (round-robin pointer last_grant, reset 1, so requester 0 wins first tie).
REQ-020 ACTIVE: header/header_valid = granted sN_header/sN_header_valid until hdr_done; header_valid=0 after hdr_done.
REQ-021 ACTIVE: header_rd routed to granted sN_header_rd; hdr_done set on header_rd while header_valid=1.
REQ-022 ACTIVE: m_axis_* = granted sN_axis_*, granted sN_axis_tready = m_axis_tready, combinational (zero added latency); data_done set on tvalid&tready&tlast.
REQ-023 Header and data completion order-independent; same-cycle completion of both allowed.
REQ-024 ACTIVE -> IDLE in cycle after both hdr_done and data_done; last_grant <= grant; pkt_cnt[grant] increments by 1, wrapping at 2^CNT_W.
REQ-025 Non-granted requester: tready=0, header_rd=0 at all times; in IDLE all sN_axis_tready=0, sN_header_rd=0, m_axis_tvalid=0, header_valid=0.
REQ-026 header_rd while header_valid=0 ignored; m_axis_tready in IDLE ignored.
REQ-027 Back-to-back: after return to IDLE, next grant follows REQ-018 (minimum 1 idle cycle between packets).
REQ-028 busy=1 exactly in ACTIVE.

Reset
REQ-029 On rst assertion, immediately: state IDLE, busy=0, grant=0, last_grant=1, hdr_done=0, data_done=0, pkt_cnt0=pkt_cnt1=0, all valid/ready/rd outputs 0.
REQ-030 Reset mid-packet aborts the packet without counter update; system resets packet_recv/packet_tx on same rst.

Structure
REQ-031 HDR_W constant, header struct (src_mac, dest_mac, ethertype) and arb state enum in ethernet_header_pkg.
REQ-032 No sub-module; round-robin pick inline.

Verification
REQ-033 s0 only: header 0x00183E04B3F2_54E1AD330D32_0800, 4 bytes 0x11..0x14 -> m_axis bytes 0x11..0x14, tlast on 0x14, s0_header_rd one pulse, pkt_cnt0=1, busy low after.
REQ-034 s0,s1 valid same cycle from reset -> s0 served first, then s1; pkt_cnt0=1, pkt_cnt1=1; no byte interleave.
REQ-035 s0 continuously valid, s1 valid -> grants alternate 0,1,0,1 over 4 packets.
REQ-036 m_axis_tready toggled 1/0 every cycle, 8-byte packet -> all 8 bytes delivered in order, no duplicates; s1_axis_tready stays 0 throughout.
REQ-037 header_rd arrives 3 cycles after tlast transfer -> stays ACTIVE until header_rd, returns IDLE next cycle.
REQ-038 rst asserted mid-payload (byte 2 of 6) -> all outputs 0 same cycle, pkt_cnt unchanged at 0, new packet after release served normally.
